// File: rtl/psum_drain_ctrl_pkg.sv
// Shared definitions for the psum drain path: FSM encoding and default widths.
// Also used by the SFU and the core controller.
package psum_drain_ctrl_pkg;

    localparam int unsigned PSUM_BW = 16;
    localparam int unsigned OUT_NIJ = 16;
    localparam int unsigned N_KIJ   = 9;
    localparam int unsigned ADDR_BW = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } drain_state_e;

    // Counter width that can hold 0..n-1; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psum_drain_ctrl.sv
// Streams OFIFO partial sums into the SFU accumulate port one pass per kernel
// position, then drains the ReLU'd bank and writes it back to psum SRAM.
module psum_drain_ctrl
    import psum_drain_ctrl_pkg::*;
#(
    parameter int unsigned psum_bw = PSUM_BW,
    parameter int unsigned out_nij = OUT_NIJ,
    parameter int unsigned n_kij   = N_KIJ,
    parameter int unsigned addr_bw = ADDR_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] out_base,
    input  logic               ofifo_valid,
    input  logic [psum_bw-1:0] ofifo_data,
    output logic               ofifo_rd,
    output logic [psum_bw-1:0] sfu_in,
    output logic               sfu_in_valid,
    output logic               sfu_out_valid,
    input  logic [psum_bw-1:0] sfu_out,
    output logic               sram_wr,
    output logic [addr_bw-1:0] sram_addr,
    output logic [psum_bw-1:0] sram_data,
    output logic               busy,
    output logic               done
);

    localparam int unsigned NIJ_W = cnt_width(out_nij);
    localparam int unsigned KIJ_W = cnt_width(n_kij);
    localparam logic [NIJ_W-1:0] NIJ_LAST = NIJ_W'(out_nij - 1);
    localparam logic [KIJ_W-1:0] KIJ_LAST = KIJ_W'(n_kij - 1);

    drain_state_e       state;
    logic [NIJ_W-1:0]   nij_cnt;
    logic [KIJ_W-1:0]   kij_cnt;
    logic [NIJ_W-1:0]   drain_idx;
    logic [addr_bw-1:0] base_q;

    // Show-ahead pop; held off during reset so an aborted tile consumes nothing more.
    assign ofifo_rd = (state == ST_ACC) && ofifo_valid && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            nij_cnt       <= '0;
            kij_cnt       <= '0;
            drain_idx     <= '0;
            base_q        <= '0;
            sfu_in        <= '0;
            sfu_in_valid  <= 1'b0;
            sfu_out_valid <= 1'b0;
            sram_wr       <= 1'b0;
            sram_addr     <= '0;
            sram_data     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            sfu_in_valid  <= 1'b0;
            sfu_out_valid <= 1'b0;
            done          <= 1'b0;

            // Write-back trails each drain strobe by one cycle.
            sram_wr <= sfu_out_valid;
            if (sfu_out_valid) begin
                sram_data <= sfu_out;
                sram_addr <= base_q + addr_bw'(drain_idx);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q  <= out_base;
                        nij_cnt <= '0;
                        kij_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (ofifo_valid) begin
                        sfu_in       <= ofifo_data;
                        sfu_in_valid <= 1'b1;
                        if (nij_cnt == NIJ_LAST) begin
                            nij_cnt <= '0;
                            if (kij_cnt == KIJ_LAST) begin
                                kij_cnt <= '0;
                                state   <= ST_DRAIN;
                            end else begin
                                kij_cnt <= kij_cnt + 1'b1;
                            end
                        end else begin
                            nij_cnt <= nij_cnt + 1'b1;
                        end
                    end
                end
                // Whole pass of out_nij strobes; the SFU pointers rely on it.
                ST_DRAIN: begin
                    sfu_out_valid <= 1'b1;
                    drain_idx     <= nij_cnt;
                    if (nij_cnt == NIJ_LAST) begin
                        nij_cnt <= '0;
                        state   <= ST_WB;
                    end else begin
                        nij_cnt <= nij_cnt + 1'b1;
                    end
                end
                ST_WB: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
